// File: rtl/cnt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cnt_pkg
//  Description : Shared constants, startup state encoding and width helper
//                for the C16M timebase / housekeeping block.
//  Revision    : 1.0  initial release
// ============================================================================
package cnt_pkg;

    // Default parameter values used by cnt_timebase and its channels
    localparam int TIMER_MAX_DEF  = 224;  // period = 225 clocks = 14.36 us at C16M
    localparam int URG_AT_DEF     = 128;
    localparam int QOS_AT_DEF     = 192;
    localparam int REF_DEPTH_DEF  = 3;
    localparam int NCH_DEF        = 2;
    localparam int BERR_TICKS_DEF = 2;
    localparam int RES_TICKS_DEF  = 12;

    // Startup sequencer states
    localparam logic [1:0] ST_WAIT = 2'd0;  // waiting for Mac reset release
    localparam logic [1:0] ST_HOLD = 2'd1;  // holding nRESout low
    localparam logic [1:0] ST_RUN  = 2'd2;  // normal operation

    // Number of bits needed to hold values 0..maxval (never less than 1)
    function automatic int cnt_w(input int maxval);
        int w;
        w = $clog2(maxval + 1);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cnt_berr_ch.sv
`default_nettype none
// ============================================================================
//  Module      : cnt_berr_ch
//  Description : One bus-error watchdog channel. Synchronises the bus-active
//                strobe, counts timer terminal counts while it stays high and
//                flags a timeout once BERR_TICKS of them have elapsed.
//  Revision    : 1.0  initial release
// ============================================================================
module cnt_berr_ch
    import cnt_pkg::*;
#(
    parameter int BERR_TICKS = BERR_TICKS_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic tc,
    input  logic bact,
    output logic timeout
);

    localparam int            CW    = cnt_w(BERR_TICKS);
    localparam logic [CW-1:0] TICKS = CW'(BERR_TICKS);

    logic          bact_s1;
    logic          act;
    logic [CW-1:0] ticks;

    // Two-flop synchroniser for the asynchronous bus-active input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bact_s1 <= 1'b0;
            act     <= 1'b0;
        end else begin
            bact_s1 <= bact;
            act     <= bact_s1;
        end
    end

    // Count terminal counts of continuous activity; timeout rises with the
    // count reaching BERR_TICKS and everything clears as soon as activity ends
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ticks   <= '0;
            timeout <= 1'b0;
        end else if (!act) begin
            ticks   <= '0;
            timeout <= 1'b0;
        end else if (tc && (ticks != TICKS)) begin
            ticks <= ticks + CW'(1);
            if ((ticks + CW'(1)) == TICKS) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cnt_timebase.sv
`default_nettype none
// ============================================================================
//  Module      : cnt_timebase
//  Description : C16M timebase for the accelerator CPLD. Free-running refresh
//                timer with credit-counted refresh handshake, per-channel
//                bus-error watchdogs, sound QoS window and a startup / warm
//                reset sequencer that latches the switch and button setup.
//  Revision    : 1.0  initial release
// ============================================================================
module cnt_timebase
    import cnt_pkg::*;
#(
    parameter int TIMER_MAX  = TIMER_MAX_DEF,
    parameter int URG_AT     = URG_AT_DEF,
    parameter int QOS_AT     = QOS_AT_DEF,
    parameter int REF_DEPTH  = REF_DEPTH_DEF,
    parameter int NCH        = NCH_DEF,
    parameter int BERR_TICKS = BERR_TICKS_DEF,
    parameter int RES_TICKS  = RES_TICKS_DEF
) (
    input  logic           C16M,
    input  logic           RES,
    input  logic [NCH-1:0] BACT,
    input  logic           RefAck,
    input  logic           nRESin,
    input  logic           nIPL2,
    input  logic [3:1]     SW,
    output logic           RefReq,
    output logic           RefUrgent,
    output logic           RefOvf,
    output logic [NCH-1:0] BERRTimeout,
    output logic           QoSGate,
    output logic           nRESout,
    output logic           nBR_IOB,
    output logic           FastROMEN
);

    localparam int            TW   = cnt_w(TIMER_MAX);
    localparam logic [TW-1:0] TMAX = TW'(TIMER_MAX);
    localparam int            CW   = cnt_w(REF_DEPTH);
    localparam logic [CW-1:0] CMAX = CW'(REF_DEPTH);
    localparam int            HW   = cnt_w(RES_TICKS);
    localparam logic [HW-1:0] HEND = HW'(RES_TICKS - 1);

    // ------------------------------------------------------------------
    // Refresh timer and credits
    // ------------------------------------------------------------------
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_nxt;
    logic          tc;
    logic [CW-1:0] credits;
    logic [CW-1:0] credits_nxt;
    logic          ovf_set;

    assign tc = (timer == TMAX);

    // Next timer value and next credit count; a TC and an RefAck arriving
    // together cancel, an RefAck with nothing pending is ignored
    always_comb begin
        timer_nxt   = tc ? '0 : (timer + TW'(1));
        credits_nxt = credits;
        ovf_set     = 1'b0;
        if (tc && !RefAck) begin
            if (credits == CMAX) begin
                ovf_set = 1'b1;
            end else begin
                credits_nxt = credits + CW'(1);
            end
        end else if (!tc && RefAck && (credits != '0)) begin
            credits_nxt = credits - CW'(1);
        end
    end

    // Timer, credit store and the refresh outputs derived from next state,
    // so RefReq/RefUrgent track the credit count without an extra cycle
    always_ff @(posedge C16M or posedge RES) begin
        if (RES) begin
            timer     <= '0;
            credits   <= '0;
            RefReq    <= 1'b0;
            RefUrgent <= 1'b0;
            RefOvf    <= 1'b0;
        end else begin
            timer     <= timer_nxt;
            credits   <= credits_nxt;
            RefReq    <= (credits_nxt != '0);
            RefUrgent <= (int'(credits_nxt) >= 2) ||
                         ((int'(credits_nxt) == 1) && (int'(timer_nxt) >= URG_AT));
            if (ovf_set) begin
                RefOvf <= 1'b1;
            end
        end
    end

    // Sound QoS window, one clock behind the timer compare
    always_ff @(posedge C16M or posedge RES) begin
        if (RES) begin
            QoSGate <= 1'b0;
        end else begin
            QoSGate <= (int'(timer) >= QOS_AT);
        end
    end

    // ------------------------------------------------------------------
    // Bus-error watchdog channels
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_berr
            cnt_berr_ch #(
                .BERR_TICKS (BERR_TICKS)
            ) u_ch (
                .clk     (C16M),
                .rst     (RES),
                .tc      (tc),
                .bact    (BACT[gi]),
                .timeout (BERRTimeout[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Startup / warm-reset sequencer
    // ------------------------------------------------------------------
    logic          nres_s1;
    logic          nres_s;
    logic          nipl_s1;
    logic          nipl_s;
    logic [2:1]    sw_s1;
    logic [2:1]    sw_s;
    logic          sw3_unused;
    logic [1:0]    state;
    logic [HW-1:0] hold;
    logic          dis;
    logic          btn;

    // SW[3] has no function in this block
    assign sw3_unused = SW[3];

    // Reset and button synchronisers idle released (high); switches idle low
    always_ff @(posedge C16M or posedge RES) begin
        if (RES) begin
            nres_s1 <= 1'b1;
            nres_s  <= 1'b1;
            nipl_s1 <= 1'b1;
            nipl_s  <= 1'b1;
            sw_s1   <= '0;
            sw_s    <= '0;
        end else begin
            nres_s1 <= nRESin;
            nres_s  <= nres_s1;
            nipl_s1 <= nIPL2;
            nipl_s  <= nipl_s1;
            sw_s1   <= SW[2:1];
            sw_s    <= sw_s1;
        end
    end

    assign dis = sw_s[1];
    assign btn = !nipl_s;

    // Sequencer: latch configuration on reset release, hold the accelerator
    // in reset for RES_TICKS terminal counts, re-enter WAIT on a Mac reset
    always_ff @(posedge C16M or posedge RES) begin
        if (RES) begin
            state     <= ST_WAIT;
            hold      <= '0;
            nRESout   <= 1'b1;
            nBR_IOB   <= 1'b1;
            FastROMEN <= 1'b0;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (nres_s) begin
                        if (dis && !btn) begin
                            nBR_IOB   <= 1'b1;
                            FastROMEN <= 1'b0;
                        end else begin
                            nBR_IOB   <= 1'b0;
                            FastROMEN <= (!sw_s[2]) ^ btn;
                        end
                        nRESout <= 1'b0;
                        hold    <= '0;
                        state   <= ST_HOLD;
                    end else begin
                        nRESout <= 1'b1;
                        nBR_IOB <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!nres_s) begin
                        nRESout <= 1'b1;
                        nBR_IOB <= 1'b1;
                        state   <= ST_WAIT;
                    end else if (tc) begin
                        hold <= hold + HW'(1);
                        if (hold == HEND) begin
                            nRESout <= 1'b1;
                            state   <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (!nres_s) begin
                        nRESout <= 1'b1;
                        nBR_IOB <= 1'b1;
                        state   <= ST_WAIT;
                    end
                end
                default: begin
                    nRESout <= 1'b1;
                    nBR_IOB <= 1'b1;
                    state   <= ST_WAIT;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cnt_timebase.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cnt_timebase
//  Description : Directed self-checking bench for cnt_timebase with default
//                parameters. Expected values are queued as stimulus is
//                applied and popped when the response is sampled.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cnt_timebase;

    localparam int TMAX = 224;

    logic       C16M;
    logic       RES;
    logic [1:0] BACT;
    logic       RefAck;
    logic       nRESin;
    logic       nIPL2;
    logic [3:1] SW;
    logic       RefReq;
    logic       RefUrgent;
    logic       RefOvf;
    logic [1:0] BERRTimeout;
    logic       QoSGate;
    logic       nRESout;
    logic       nBR_IOB;
    logic       FastROMEN;

    int checks = 0;
    int errors = 0;
    int tmr;

    typedef struct {
        string       tag;
        logic [15:0] exp;
    } exp_t;

    exp_t sb[$];

    cnt_timebase dut (
        .C16M        (C16M),
        .RES         (RES),
        .BACT        (BACT),
        .RefAck      (RefAck),
        .nRESin      (nRESin),
        .nIPL2       (nIPL2),
        .SW          (SW),
        .RefReq      (RefReq),
        .RefUrgent   (RefUrgent),
        .RefOvf      (RefOvf),
        .BERRTimeout (BERRTimeout),
        .QoSGate     (QoSGate),
        .nRESout     (nRESout),
        .nBR_IOB     (nBR_IOB),
        .FastROMEN   (FastROMEN)
    );

    initial C16M = 1'b0;
    always #5 C16M = ~C16M;

    // Reference timer: value the DUT timer should hold after each edge
    always @(posedge C16M or posedge RES) begin
        if (RES) tmr <= 0;
        else     tmr <= (tmr == TMAX) ? 0 : tmr + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge C16M);
        #1;
    endtask

    task automatic push(input string tag, input logic [15:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [15:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed %0h expected none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic to_tmr(input int target);
        int guard;
        guard = 0;
        while (tmr != target && guard < 300) begin
            tick(1);
            guard++;
        end
    endtask

    // Advance to just after the next terminal count
    task automatic after_tc();
        tick(1);
        to_tmr(0);
    endtask

    function automatic logic [15:0] all_outs();
        return {7'd0, RefReq, RefUrgent, RefOvf, BERRTimeout, QoSGate,
                nRESout, nBR_IOB, FastROMEN};
    endfunction

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        RES    = 1'b1;
        BACT   = 2'b00;
        RefAck = 1'b0;
        nRESin = 1'b1;
        nIPL2  = 1'b1;
        SW     = 3'b000;

        // ---------------- reset values ----------------
        push("reset_outs", 16'h006);
        tick(3);
        check(all_outs());
        RES = 1'b0;

        // First edge: sequencer decodes SW=000, button released
        push("por_decode", 16'h001);
        tick(1);
        check({nRESout, nBR_IOB, FastROMEN});

        // ---------------- refresh credits ----------------
        push("req_idle", 16'h0);
        to_tmr(127);
        check(RefReq);

        push("tc1_flags", 16'h4);
        after_tc();
        check({RefReq, RefUrgent, RefOvf});
        push("tc1_urg127", 16'h0);
        to_tmr(127);
        check(RefUrgent);
        push("tc1_urg128", 16'h1);
        to_tmr(128);
        check(RefUrgent);

        push("qos_192", 16'h0);
        to_tmr(192);
        check(QoSGate);
        push("qos_193", 16'h1);
        tick(1);
        check(QoSGate);

        push("qos_wrap", 16'h1);
        after_tc();
        check(QoSGate);
        push("tc2_flags", 16'h6);
        check({RefReq, RefUrgent, RefOvf});
        push("qos_low", 16'h0);
        tick(1);
        check(QoSGate);

        push("tc3_flags", 16'h6);
        after_tc();
        check({RefReq, RefUrgent, RefOvf});
        push("tc4_ovf", 16'h7);
        after_tc();
        check({RefReq, RefUrgent, RefOvf});

        // Two acks bring credits from 3 down to 1
        push("ack1", 16'h3);
        RefAck = 1'b1;
        tick(1);
        RefAck = 1'b0;
        check({RefReq, RefUrgent});
        push("ack2", 16'h5);
        RefAck = 1'b1;
        tick(1);
        RefAck = 1'b0;
        check({RefReq, RefUrgent, RefOvf});

        // Ack coincident with TC leaves the single credit in place
        to_tmr(TMAX);
        push("ack_tc", 16'h2);
        RefAck = 1'b1;
        tick(1);
        RefAck = 1'b0;
        check({RefReq, RefUrgent});

        push("ack_last", 16'h0);
        RefAck = 1'b1;
        tick(1);
        RefAck = 1'b0;
        check(RefReq);

        push("ack_empty", 16'h0);
        RefAck = 1'b1;
        tick(1);
        RefAck = 1'b0;
        check({RefReq, RefUrgent});

        push("tc_after_empty", 16'h2);
        after_tc();
        check({RefReq, RefUrgent});

        // ---------------- bus-error watchdogs ----------------
        BACT = 2'b01;
        push("berr_tc1", 16'h0);
        after_tc();
        check(BERRTimeout);
        push("berr_pre2", 16'h0);
        to_tmr(TMAX);
        check(BERRTimeout);
        push("berr_tc2", 16'h1);
        tick(1);
        check(BERRTimeout);

        BACT = 2'b00;
        push("berr_drop2", 16'h1);
        tick(2);
        check(BERRTimeout);
        push("berr_clr", 16'h0);
        tick(1);
        check(BERRTimeout);

        to_tmr(100);
        BACT = 2'b10;
        push("berr1_tc1", 16'h0);
        after_tc();
        check(BERRTimeout);
        push("berr1_tc2", 16'h2);
        after_tc();
        check(BERRTimeout);

        // ---------------- startup sequencer ----------------
        // Mac reset while still holding from power-up
        nRESin = 1'b0;
        push("hold_abort_pre", 16'h0);
        tick(2);
        check(nRESout);
        push("hold_abort", 16'h3);
        tick(1);
        check({nRESout, nBR_IOB});

        tick(5);
        nRESin = 1'b1;
        push("relA_pre", 16'h3);
        tick(2);
        check({nRESout, nBR_IOB});
        push("relA_decode", 16'h1);
        tick(1);
        check({nRESout, nBR_IOB, FastROMEN});

        for (int i = 0; i < 11; i++) after_tc();
        push("relA_tc11", 16'h0);
        check(nRESout);
        push("relA_tc12", 16'h5);
        after_tc();
        check({nRESout, nBR_IOB, FastROMEN});

        // Warm reset from RUN with the disable switch set
        SW     = 3'b001;
        nRESin = 1'b0;
        push("warm_wait", 16'h3);
        tick(3);
        check({nRESout, nBR_IOB});
        tick(5);
        nRESin = 1'b1;
        push("relB_decode", 16'h2);
        tick(3);
        check({nRESout, nBR_IOB, FastROMEN});
        push("relB_hold", 16'h0);
        after_tc();
        after_tc();
        check(nRESout);

        // Abort from HOLD, then release with the button pressed
        nIPL2  = 1'b0;
        nRESin = 1'b0;
        push("abortB", 16'h3);
        tick(3);
        check({nRESout, nBR_IOB});
        tick(3);
        nRESin = 1'b1;
        push("relC_decode", 16'h0);
        tick(3);
        check({nRESout, nBR_IOB, FastROMEN});

        // Asynchronous reset in the middle of HOLD
        after_tc();
        tick(3);
        push("pre_res", 16'h6);
        check({RefOvf, BERRTimeout[1], nRESout});
        #2;
        RES = 1'b1;
        push("async_rst", 16'h006);
        #1;
        check(all_outs());

        tick(2);
        RES  = 1'b0;
        BACT = 2'b00;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
